// File: rtl/ff_pkg.sv
// Shared definitions for the stateff flip-flop and its checker: FSM encodings,
// flip-flop type names and default counter width.
package ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam string FF_DFF    = "DFF";
    localparam string FF_TFF    = "TFF";
    localparam int    CNT_W_DEF = 16;

endpackage

// File: rtl/ff_checker_if.sv
// Checker bus: stimulus and DUT outputs in (slave side), check results out.
interface ff_checker_if
    import ff_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             en;
    logic             d_in;
    logic             q_in;
    logic             qn_in;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    logic [CNT_W-1:0] first_err_cycle;
    state_t           state;

    modport master (
        output en, d_in, q_in, qn_in,
        input  mismatch, err_sticky, err_count, check_count, first_err_cycle, state
    );

    modport slave (
        input  en, d_in, q_in, qn_in,
        output mismatch, err_sticky, err_count, check_count, first_err_cycle, state
    );

endinterface

// File: rtl/ff_ref_model.sv
// Golden flip-flop: holds what a correct DUT Q must be after each edge.
// Tracks on every non-reset edge, independent of any checker state.
module ff_ref_model
    import ff_pkg::*;
#(
    parameter string FF_TYPE = FF_DFF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic exp_q
);
    localparam bit IS_TFF = (FF_TYPE == FF_TFF);

    always_ff @(posedge clk) begin
        if (rst)
            exp_q <= 1'b0;
        else
            exp_q <= IS_TFF ? (exp_q ^ d_in) : d_in;
    end

endmodule

// File: rtl/ff_checker.sv
// Monitor stage for stateff: compares DUT Q/Qn against the golden flop,
// counts checked cycles and errors, and latches the first failing cycle.
module ff_checker
    import ff_pkg::*;
#(
    parameter string FF_TYPE     = FF_DFF,
    parameter int    CNT_W       = CNT_W_DEF,
    parameter bit    HALT_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    ff_checker_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             exp_q;
    logic             bad;
    logic             checked;
    logic             hit_max;
    logic [CNT_W-1:0] chk_inc;
    logic [CNT_W-1:0] err_inc;
    logic             mis_q;
    logic             sticky_q;
    logic [CNT_W-1:0] chk_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] first_q;
    state_t           st_q;
    state_t           st_d;

    ff_ref_model #(.FF_TYPE(FF_TYPE)) u_ref (
        .clk   (clk),
        .rst   (rst),
        .d_in  (bus.d_in),
        .exp_q (exp_q)
    );

    // Case-inequality so X/Z from the DUT is reported rather than masked.
    always_comb bad = (bus.q_in !== exp_q) || (bus.qn_in !== ~bus.q_in);

    assign checked = (st_q == ST_CHECK) && bus.en;
    assign chk_inc = (chk_q == CNT_MAX) ? CNT_MAX : chk_q + CNT_W'(1);
    assign err_inc = (err_q == CNT_MAX) ? CNT_MAX : err_q + CNT_W'(1);
    assign hit_max = (chk_inc == CNT_MAX);

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  if (bus.en) st_d = ST_CHECK;
            ST_CHECK: begin
                if (!bus.en)
                    st_d = ST_IDLE;
                else if ((bad && HALT_ON_ERR) || hit_max)
                    st_d = ST_HALT;
            end
            ST_HALT:  st_d = ST_HALT;
            default:  st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            mis_q    <= 1'b0;
            sticky_q <= 1'b0;
            chk_q    <= '0;
            err_q    <= '0;
            first_q  <= '0;
        end else begin
            st_q  <= st_d;
            mis_q <= checked && bad;
            if (checked) begin
                chk_q <= chk_inc;
                if (bad) begin
                    err_q <= err_inc;
                    if (!sticky_q) begin
                        first_q  <= chk_q;
                        sticky_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mismatch        = mis_q;
    assign bus.err_sticky      = sticky_q;
    assign bus.err_count       = err_q;
    assign bus.check_count     = chk_q;
    assign bus.first_err_cycle = first_q;
    assign bus.state           = st_q;

endmodule

// File: tb/tb_ff_checker.sv
// Bench for ff_checker: four configurations share one stimulus stream and are
// each compared every cycle against a behavioural model, plus directed checks.
module tb_ff_checker;
    import ff_pkg::*;

    logic clk = 1'b0;
    logic rst, en, d, q, qn;

    always #5 clk = ~clk;

    ff_checker_if #(.CNT_W(16)) b0 ();
    ff_checker_if #(.CNT_W(16)) b1 ();
    ff_checker_if #(.CNT_W(16)) b2 ();
    ff_checker_if #(.CNT_W(4))  b3 ();

    assign {b0.en, b0.d_in, b0.q_in, b0.qn_in} = {en, d, q, qn};
    assign {b1.en, b1.d_in, b1.q_in, b1.qn_in} = {en, d, q, qn};
    assign {b2.en, b2.d_in, b2.q_in, b2.qn_in} = {en, d, q, qn};
    assign {b3.en, b3.d_in, b3.q_in, b3.qn_in} = {en, d, q, qn};

    ff_checker #(.FF_TYPE("DFF"), .CNT_W(16), .HALT_ON_ERR(1'b0)) u_dff  (.clk(clk), .rst(rst), .bus(b0));
    ff_checker #(.FF_TYPE("TFF"), .CNT_W(16), .HALT_ON_ERR(1'b0)) u_tff  (.clk(clk), .rst(rst), .bus(b1));
    ff_checker #(.FF_TYPE("DFF"), .CNT_W(16), .HALT_ON_ERR(1'b1)) u_halt (.clk(clk), .rst(rst), .bus(b2));
    ff_checker #(.FF_TYPE("DFF"), .CNT_W(4),  .HALT_ON_ERR(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(b3));

    int tests = 0;
    int fails = 0;

    // Model: golden Q from input history (last d / parity of ones since reset)
    int m_last_d = 0;
    int m_ones   = 0;
    int m_istff[4] = '{0, 1, 0, 0};
    int m_halt[4]  = '{0, 0, 1, 0};
    int m_max[4]   = '{65535, 65535, 65535, 15};
    int m_chk[4], m_err[4], m_first[4], m_st[4], m_sticky[4], m_mis[4];

    function automatic bit ref_q(int tff);
        return (tff != 0) ? ((m_ones % 2) != 0) : (m_last_d != 0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_model();
        for (int i = 0; i < 4; i++) begin
            bit bad;
            bad = (q !== ref_q(m_istff[i])) || (qn !== ~q);
            m_mis[i] = 0;
            if (rst) begin
                m_chk[i] = 0; m_err[i] = 0; m_first[i] = 0; m_sticky[i] = 0; m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (en) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (!en) m_st[i] = 0;
                else begin
                    if (bad) begin
                        m_mis[i] = 1;
                        if (m_sticky[i] == 0) begin m_first[i] = m_chk[i]; m_sticky[i] = 1; end
                        if (m_err[i] < m_max[i]) m_err[i]++;
                        if (m_halt[i] != 0) m_st[i] = 2;
                    end
                    if (m_chk[i] < m_max[i]) m_chk[i]++;
                    if (m_chk[i] == m_max[i]) m_st[i] = 2;
                end
            end
        end
        if (rst) begin m_last_d = 0; m_ones = 0; end
        else begin m_last_d = int'(d); m_ones += int'(d); end
    endtask

    task automatic get_act(int i, output logic [31:0] mis, sticky, err, chk, first, st);
        case (i)
            0: begin mis = 32'(b0.mismatch); sticky = 32'(b0.err_sticky); err = 32'(b0.err_count);
                     chk = 32'(b0.check_count); first = 32'(b0.first_err_cycle); st = 32'(b0.state); end
            1: begin mis = 32'(b1.mismatch); sticky = 32'(b1.err_sticky); err = 32'(b1.err_count);
                     chk = 32'(b1.check_count); first = 32'(b1.first_err_cycle); st = 32'(b1.state); end
            2: begin mis = 32'(b2.mismatch); sticky = 32'(b2.err_sticky); err = 32'(b2.err_count);
                     chk = 32'(b2.check_count); first = 32'(b2.first_err_cycle); st = 32'(b2.state); end
            default: begin mis = 32'(b3.mismatch); sticky = 32'(b3.err_sticky); err = 32'(b3.err_count);
                     chk = 32'(b3.check_count); first = 32'(b3.first_err_cycle); st = 32'(b3.state); end
        endcase
    endtask

    task automatic compare_all();
        logic [31:0] mis, sticky, err, chk, first, st;
        for (int i = 0; i < 4; i++) begin
            get_act(i, mis, sticky, err, chk, first, st);
            check($sformatf("model[%0d].mismatch", i),    mis,    32'(m_mis[i]));
            check($sformatf("model[%0d].err_sticky", i),  sticky, 32'(m_sticky[i]));
            check($sformatf("model[%0d].err_count", i),   err,    32'(m_err[i]));
            check($sformatf("model[%0d].check_count", i), chk,    32'(m_chk[i]));
            check($sformatf("model[%0d].first_err", i),   first,  32'(m_first[i]));
            check($sformatf("model[%0d].state", i),       st,     32'(m_st[i]));
        end
    endtask

    // Drive one cycle, clock it, then sample 1 time unit after the edge.
    task automatic cycle(bit r, bit e, bit dd, bit qq, bit qqn);
        rst = r; en = e; d = dd; q = qq; qn = qqn;
        @(posedge clk);
        step_model();
        #1;
        compare_all();
    endtask

    // Present a correct DUT of type tgt (0 DFF, 1 TFF), optionally corrupted.
    task automatic drv(bit r, bit e, bit dd, int tgt, bit inv_q, bit qn_bad);
        bit qq;
        qq = ref_q(tgt) ^ inv_q;
        cycle(r, e, dd, qq, qn_bad ? qq : ~qq);
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit r, e, dd, qq, qqn;
        int mis, chk, err, first, st;
    } vec_t;

    vec_t tbl[9];
    int   mis_seen;

    initial begin
        // Hand-derived expectations for the DFF checker
        tbl[0] = '{1, 0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 1,  0, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, 1};
        tbl[3] = '{0, 1, 1, 1, 0,  1, 2, 1, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 0,  0, 2, 1, 1, 0};
        tbl[5] = '{0, 0, 1, 1, 0,  0, 2, 1, 1, 0};
        tbl[6] = '{0, 1, 1, 1, 1,  0, 2, 1, 1, 1};
        tbl[7] = '{0, 1, 0, 1, 1,  1, 3, 2, 1, 1};
        tbl[8] = '{1, 1, 1, 0, 1,  0, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].dd, tbl[i].qq, tbl[i].qqn);
            check($sformatf("tbl[%0d].mismatch", i),    32'(b0.mismatch),        32'(tbl[i].mis));
            check($sformatf("tbl[%0d].check_count", i), 32'(b0.check_count),     32'(tbl[i].chk));
            check($sformatf("tbl[%0d].err_count", i),   32'(b0.err_count),       32'(tbl[i].err));
            check($sformatf("tbl[%0d].first_err", i),   32'(b0.first_err_cycle), 32'(tbl[i].first));
            check($sformatf("tbl[%0d].state", i),       32'(b0.state),           32'(tbl[i].st));
        end

        // Clean DFF run: one arming cycle then 50 checked cycles
        do_reset();
        mis_seen = 0;
        for (int k = 0; k < 51; k++) begin
            drv(0, 1, 1'($urandom), 0, 0, 0);
            mis_seen += int'(b0.mismatch);
        end
        check("clean.mismatch_pulses", 32'(mis_seen), 32'd0);
        check("clean.check_count", 32'(b0.check_count), 32'd50);
        check("clean.err_count", 32'(b0.err_count), 32'd0);
        check("clean.err_sticky", 32'(b0.err_sticky), 32'd0);

        // Inverted Q on checked cycle 10
        do_reset();
        drv(0, 1, 1'($urandom), 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            drv(0, 1, 1'($urandom), 0, k == 10, 0);
            if (k == 10) check("invq.pulse", 32'(b0.mismatch), 32'd1);
            if (k == 11) check("invq.pulse_end", 32'(b0.mismatch), 32'd0);
        end
        check("invq.err_count", 32'(b0.err_count), 32'd1);
        check("invq.first_err", 32'(b0.first_err_cycle), 32'd10);
        check("invq.err_sticky", 32'(b0.err_sticky), 32'd1);

        // TFF with T=1: DUT toggles, 8 checked cycles
        do_reset();
        drv(0, 1, 1, 1, 0, 0);
        mis_seen = 0;
        for (int k = 0; k < 8; k++) begin
            drv(0, 1, 1, 1, 0, 0);
            mis_seen += int'(b1.mismatch);
        end
        check("tff.mismatch_pulses", 32'(mis_seen), 32'd0);
        check("tff.check_count", 32'(b1.check_count), 32'd8);
        check("tff.err_count", 32'(b1.err_count), 32'd0);

        // Qn stuck at 0 while Q=0 on checked cycle 3
        do_reset();
        drv(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) drv(0, 1, 0, 0, 0, k == 3);
        check("qn.err_count", 32'(b0.err_count), 32'd1);
        check("qn.first_err", 32'(b0.first_err_cycle), 32'd3);

        // Halt-on-error: first error on checked cycle 5, errors continue
        do_reset();
        drv(0, 1, 1'($urandom), 0, 0, 0);
        mis_seen = 0;
        for (int k = 0; k < 10; k++) begin
            drv(0, 1, 1'($urandom), 0, k >= 5, 0);
            mis_seen += int'(b2.mismatch);
        end
        check("halt.state", 32'(b2.state), 32'(ST_HALT));
        check("halt.err_count", 32'(b2.err_count), 32'd1);
        check("halt.check_count", 32'(b2.check_count), 32'd6);
        check("halt.mismatch_pulses", 32'(mis_seen), 32'd1);
        check("halt.mismatch_after", 32'(b2.mismatch), 32'd0);
        drv(1, 1, 0, 0, 1, 0);
        check("halt.rst_state", 32'(b2.state), 32'(ST_IDLE));
        check("halt.rst_check_count", 32'(b2.check_count), 32'd0);
        check("halt.rst_err_count", 32'(b2.err_count), 32'd0);

        // 4-bit counters: pause via en, then run into saturation
        do_reset();
        drv(0, 1, 1'($urandom), 0, 0, 0);
        mis_seen = 0;
        for (int k = 0; k < 5; k++) drv(0, 1, 1'($urandom), 0, 0, 0);
        for (int k = 0; k < 3; k++) drv(0, 0, 1'($urandom), 0, 0, 0);
        check("sat.pause_count", 32'(b3.check_count), 32'd5);
        drv(0, 1, 1'($urandom), 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            drv(0, 1, 1'($urandom), 0, 0, 0);
            mis_seen += int'(b3.mismatch);
        end
        check("sat.mismatch_pulses", 32'(mis_seen), 32'd0);
        check("sat.check_count", 32'(b3.check_count), 32'd15);
        check("sat.state", 32'(b3.state), 32'(ST_HALT));

        // Random traffic, all configurations against the model every cycle
        for (int k = 0; k < 400; k++) begin
            drv(($urandom % 40) == 0, ($urandom % 4) != 0, 1'($urandom),
                int'($urandom % 2), ($urandom % 10) == 0, ($urandom % 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ff_checker.md
Name: ff_checker

Overview:
- Self-checking monitor stage that sits directly downstream of the stateff flip-flop.
- Consumes the flip-flop's stimulus (rst, D/T) and its outputs (Q, Qn), and runs a cycle-accurate reference model of the selected flip-flop type.
- Flags mismatches, counts checked cycles and errors, and records the first failing cycle.
- Synthesizable, so it can run in simulation benches and on-board next to the DUT.

Parameters:
- FF_TYPE, "DFF", model type: "DFF" gives Q+ = D; "TFF" gives Q+ = Q ^ T.
- CNT_W, 16, width of check_count, err_count and first_err_cycle.
- HALT_ON_ERR, 0, when 1 the first mismatch freezes all counters (HALT state).

Ports:
- clk  in  1  rising-edge clock, shared with the DUT.
- rst  in  1  synchronous active-high reset, same signal that drives the DUT.
- en  in  1  checking enable; the model tracks regardless of en.
- d_in  in  1  D (DFF) or T (TFF) value presented to the DUT this cycle.
- q_in  in  1  DUT Q.
- qn_in  in  1  DUT Qn.
- mismatch  out  1  one-cycle pulse, registered.
- err_sticky  out  1  set on first mismatch, cleared only by rst.
- err_count  out  CNT_W  number of mismatching checked cycles, saturating.
- check_count  out  CNT_W  number of checked cycles, saturating.
- first_err_cycle  out  CNT_W  check_count value at the first mismatch.
- state  out  2  00 IDLE, 01 CHECK, 10 HALT.

Behaviour:
- Everything is updated on rising clk only. rst is synchronous and active-high.
- Reset (rst=1 at edge):
  - exp_q=0, state=IDLE, mismatch=0, err_sticky=0.
  - All counters and first_err_cycle = 0.
- Reference model (every non-reset edge, in every state):
  - DFF: exp_q <= d_in.
  - TFF: exp_q <= exp_q ^ d_in.
  - exp_q therefore always equals what a correct DUT Q holds after the same edge.
- Compare (combinational, evaluated in cycle t): bad = (q_in != exp_q) | (qn_in != ~q_in).
  - In simulation, X/Z on q_in or qn_in counts as bad (case-inequality).
- Checked cycle: state==CHECK, en=1, rst=0.
- On a checked cycle at the edge ending cycle t:
  - check_count++ (saturates at all-ones).
  - If bad:
    - mismatch=1 for cycle t+1.
    - err_count++ (saturating).
    - If err_sticky was 0: first_err_cycle <= pre-increment check_count, and err_sticky <= 1.
- Latency: an error present in cycle t appears on mismatch in cycle t+1. mismatch is 0 in every other cycle.
- State transitions:
  - IDLE -> CHECK when en=1. The first checked cycle is the one after this transition.
  - CHECK -> IDLE when en=0.
  - CHECK -> HALT on a bad checked cycle if HALT_ON_ERR=1.
  - CHECK -> HALT when check_count reaches all-ones.
  - HALT -> HALT until rst. In HALT: counters frozen, mismatch=0, model keeps tracking.
- Simultaneous events:
  - rst dominates en and bad.
  - Bad on the cycle check_count saturates: counted, then HALT.
- Reset mid-operation: everything clears in one edge, including a pending mismatch pulse.
  - The cycle in which rst=1 is not checked. The DUT is also resetting during that cycle.
- Toggling en never desynchronizes the model, because exp_q is independent of state.

Decomposition:
- Shared package ff_pkg:
  - state encodings ST_IDLE / ST_CHECK / ST_HALT.
  - FF_TYPE string constants "DFF" / "TFF".
  - Default CNT_W.
  - The same package serves stateff.
- One natural sub-module: ff_ref_model (clk, rst, d_in -> exp_q, FF_TYPE parameter). It is the golden flop, kept separate so it can be reused by other benches.
- Counters and the FSM stay in ff_checker.

Test Plan:
- Correct DFF, rst 2 cycles, then en=1 for 50 cycles of random d_in -> mismatch never 1; check_count=50, err_count=0, err_sticky=0.
- DFF with q_in forced inverted on checked cycle 10 only -> mismatch pulse exactly one cycle later; err_count=1, first_err_cycle=10, err_sticky=1.
- FF_TYPE="TFF", d_in=1 constant for 8 checked cycles, correct DUT -> q_in toggles 0,1,0,1...; no mismatch, check_count=8.
- qn_in stuck at 0 while q_in=0 on checked cycle 3 -> complement error flagged; err_count=1, first_err_cycle=3.
- HALT_ON_ERR=1, error injected on checked cycle 5 then further errors -> state=10; err_count stays 1, check_count stays 6, mismatch 0 afterwards; rst returns state to IDLE with counters 0.
- CNT_W=4, 20 checked cycles -> check_count saturates at 15, state=HALT. Also toggle en off/on mid-run: counts pause, no false mismatch on resume.
